// File: rtl/frame_buffer.sv
// Ping-pong frame buffer between the downsampler and the FFT: two banks of
// FRAME_LEN complex samples, filled in order and streamed out with ready/valid.
module frame_buffer #(
  parameter int FRAME_LEN = 64,
  parameter int DATA_W    = 32
) (
  input  logic                         slow_clk,
  input  logic                         reset,
  input  logic                         din_valid,
  input  logic signed [DATA_W-1:0]     din_re_Fs,
  input  logic signed [DATA_W-1:0]     din_im_Fs,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic signed [DATA_W-1:0]     dout_re,
  output logic signed [DATA_W-1:0]     dout_im,
  output logic [$clog2(FRAME_LEN)-1:0] dout_idx,
  output logic                         dout_last,
  output logic                         overflow
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_STREAM} rd_state_t;

  rd_state_t                rd_state;
  logic signed [DATA_W-1:0] mem_re [2*FRAME_LEN];
  logic signed [DATA_W-1:0] mem_im [2*FRAME_LEN];
  logic [1:0]               full;
  logic                     wr_bank;
  logic                     rd_bank;
  logic [IDX_W-1:0]         wr_idx;
  logic [IDX_W-1:0]         rd_nxt_idx;
  logic [IDX_W:0]           rd_addr;
  logic                     rd_xfer;
  logic                     rd_done;
  logic                     rd_fetch;
  logic                     wr_ok;
  logic                     wr_drop;

  always_comb begin
    rd_xfer    = (rd_state == RD_STREAM) && dout_valid && dout_ready;
    rd_done    = rd_xfer && dout_last;
    // A fetch loads the output register straight from the array, so a new
    // word is ready on the edge that retires the previous one.
    rd_fetch   = (rd_state == RD_LOAD) || (rd_xfer && !dout_last);
    rd_nxt_idx = (rd_state == RD_STREAM) ? dout_idx + IDX_W'(1) : '0;
    rd_addr    = {rd_bank, rd_nxt_idx};
    // A full write bank is still writable when its last word leaves this edge.
    wr_ok      = din_valid && (!full[wr_bank] || (rd_done && (rd_bank == wr_bank)));
    wr_drop    = din_valid && !wr_ok;
  end

  always_ff @(posedge slow_clk) begin
    if (wr_ok) begin
      mem_re[{wr_bank, wr_idx}] <= din_re_Fs;
      mem_im[{wr_bank, wr_idx}] <= din_im_Fs;
    end
  end

  always_ff @(posedge slow_clk or negedge reset) begin
    if (!reset) begin
      rd_state   <= RD_IDLE;
      full       <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_idx     <= '0;
      overflow   <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      dout_idx   <= '0;
      dout_re    <= '0;
      dout_im    <= '0;
    end else begin
      if (wr_ok) begin
        wr_idx <= wr_idx + IDX_W'(1);
        if (wr_idx == LAST_IDX) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (wr_drop)
        overflow <= 1'b1;

      if (rd_fetch) begin
        dout_valid <= 1'b1;
        dout_idx   <= rd_nxt_idx;
        dout_last  <= (rd_nxt_idx == LAST_IDX);
        dout_re    <= mem_re[rd_addr];
        dout_im    <= mem_im[rd_addr];
      end

      case (rd_state)
        RD_IDLE:
          if (full[rd_bank])
            rd_state <= RD_LOAD;
        RD_LOAD:
          rd_state <= RD_STREAM;
        RD_STREAM:
          if (rd_done) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
            dout_valid    <= 1'b0;
            dout_last     <= 1'b0;
            rd_state      <= full[~rd_bank] ? RD_LOAD : RD_IDLE;
          end
        default:
          rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer.sv
// Directed self-checking bench for frame_buffer (FRAME_LEN=64, DATA_W=32).
module tb_frame_buffer;

  localparam int FRAME_LEN = 64;
  localparam int DATA_W    = 32;
  localparam int IDX_W     = 6;

  logic                     slow_clk   = 1'b0;
  logic                     reset      = 1'b1;
  logic                     din_valid  = 1'b0;
  logic                     dout_ready = 1'b0;
  logic signed [DATA_W-1:0] din_re_Fs  = '0;
  logic signed [DATA_W-1:0] din_im_Fs  = '0;
  logic                     dout_valid;
  logic                     dout_last;
  logic                     overflow;
  logic signed [DATA_W-1:0] dout_re;
  logic signed [DATA_W-1:0] dout_im;
  logic [IDX_W-1:0]         dout_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 slow_clk = ~slow_clk;

  frame_buffer #(.FRAME_LEN(FRAME_LEN), .DATA_W(DATA_W)) dut (
    .slow_clk  (slow_clk),
    .reset     (reset),
    .din_valid (din_valid),
    .din_re_Fs (din_re_Fs),
    .din_im_Fs (din_im_Fs),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_re   (dout_re),
    .dout_im   (dout_im),
    .dout_idx  (dout_idx),
    .dout_last (dout_last),
    .overflow  (overflow)
  );

  // Quadrature word carries the sample number with the top nibble set.
  function automatic logic [DATA_W-1:0] im_of(input int v);
    return 32'hF000_0000 + DATA_W'(v);
  endfunction

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic drive(input logic v, input int val);
    din_valid = v;
    din_re_Fs = DATA_W'(val);
    din_im_Fs = im_of(val);
  endtask

  task automatic do_reset();
    drive(1'b0, 0);
    dout_ready = 1'b0;
    #2;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 64; i++) begin drive(1'b1, 256 + i); tick(); end
    drive(1'b0, 0);
    tick(); tick();
    n_checks++;
    if (dout_valid !== 1'b1 || dout_re !== DATA_W'(256)) begin
      n_fail++;
      $display("FAIL reset_precond: v=%b re=%0d, expected v=1 re=256", dout_valid, dout_re);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (dout_valid !== 1'b0 || dout_last !== 1'b0 || dout_idx !== '0 ||
        dout_re !== '0 || dout_im !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: v=%b last=%b idx=%0d re=%h im=%h ovf=%b, expected all 0",
               dout_valid, dout_last, dout_idx, dout_re, dout_im, overflow);
    end
    tick();
    reset = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (dout_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: v=%b ovf=%b, expected 0 0", dout_valid, overflow);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin drive(1'b1, i); tick(); end
    drive(1'b0, 0);
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_lat0: dout_valid=%b, expected 0", dout_valid);
    end
    tick();
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_lat1: dout_valid=%b, expected 0", dout_valid);
    end
    tick();
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (dout_valid !== 1'b1 || dout_re !== DATA_W'(i) || dout_im !== im_of(i) ||
          dout_idx !== IDX_W'(i) || dout_last !== (i == 63)) begin
        n_fail++;
        $display("FAIL single_word[%0d]: v=%b re=%0d im=%h idx=%0d last=%b, expected v=1 re=%0d idx=%0d last=%b",
                 i, dout_valid, dout_re, dout_im, dout_idx, dout_last, i, i, (i == 63));
      end
      tick();
    end
    n_checks++;
    if (dout_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL single_end: v=%b ovf=%b, expected 0 0", dout_valid, overflow);
    end
  endtask

  task automatic test_two_frames();
    int exp_n, gap, max_gap;
    bit started;
    exp_n = 0; gap = 0; max_gap = 0; started = 0;
    do_reset();
    dout_ready = 1'b1;
    for (int c = 0; c < 400 && exp_n < 128; c++) begin
      if (c < 128) drive(1'b1, c); else drive(1'b0, 0);
      if (dout_valid === 1'b1) begin
        n_checks++;
        if (dout_re !== DATA_W'(exp_n) || dout_im !== im_of(exp_n) ||
            dout_idx !== IDX_W'(exp_n % 64) || dout_last !== ((exp_n % 64) == 63)) begin
          n_fail++;
          $display("FAIL two_word[%0d]: re=%0d idx=%0d last=%b, expected re=%0d idx=%0d",
                   exp_n, dout_re, dout_idx, dout_last, exp_n, exp_n % 64);
        end
        if (started && gap > max_gap) max_gap = gap;
        started = 1; gap = 0; exp_n++;
      end else if (started) gap++;
      tick();
    end
    drive(1'b0, 0);
    n_checks++;
    if (exp_n != 128) begin
      n_fail++; $display("FAIL two_count: got %0d words, expected 128", exp_n);
    end
    n_checks++;
    if (max_gap > 1) begin
      n_fail++; $display("FAIL two_gap: max gap %0d cycles, expected <= 1", max_gap);
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL two_ovf: overflow=%b, expected 0", overflow);
    end
  endtask

  task automatic test_overflow();
    int exp_n;
    exp_n = 0;
    do_reset();
    for (int i = 0; i < 128; i++) begin drive(1'b1, i); tick(); end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_before: overflow=%b, expected 0", overflow);
    end
    drive(1'b1, 128);
    tick();
    drive(1'b0, 0);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: overflow=%b, expected 1", overflow);
    end
    repeat (3) tick();
    n_checks++;
    if (overflow !== 1'b1 || dout_valid !== 1'b1 || dout_idx !== '0 || dout_re !== '0) begin
      n_fail++;
      $display("FAIL ovf_stall: ovf=%b v=%b idx=%0d re=%0d, expected 1 1 0 0",
               overflow, dout_valid, dout_idx, dout_re);
    end
    dout_ready = 1'b1;
    for (int c = 0; c < 300 && exp_n < 128; c++) begin
      if (dout_valid === 1'b1) begin
        n_checks++;
        if (dout_re !== DATA_W'(exp_n) || dout_im !== im_of(exp_n) ||
            dout_idx !== IDX_W'(exp_n % 64) || dout_last !== ((exp_n % 64) == 63)) begin
          n_fail++;
          $display("FAIL ovf_word[%0d]: re=%0d idx=%0d last=%b, expected re=%0d idx=%0d",
                   exp_n, dout_re, dout_idx, dout_last, exp_n, exp_n % 64);
        end
        exp_n++;
      end
      tick();
    end
    n_checks++;
    if (exp_n != 128) begin
      n_fail++; $display("FAIL ovf_count: got %0d words, expected 128", exp_n);
    end
    repeat (4) tick();
    n_checks++;
    if (dout_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: v=%b ovf=%b, expected v=0 ovf=1", dout_valid, overflow);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: overflow=%b, expected 0", overflow);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [15:0]        pat;
    logic               hold_v;
    logic [DATA_W-1:0]  h_re, h_im;
    logic [IDX_W-1:0]   h_idx;
    logic               h_last;
    int                 exp_n;
    pat = 16'b1011_0010_1110_0101;
    hold_v = 1'b0; h_re = '0; h_im = '0; h_idx = '0; h_last = 1'b0; exp_n = 0;
    do_reset();
    for (int c = 0; c < 800 && exp_n < 128; c++) begin
      if (c < 128) drive(1'b1, c); else drive(1'b0, 0);
      if (hold_v) begin
        n_checks++;
        if (dout_valid !== 1'b1 || dout_re !== h_re || dout_im !== h_im ||
            dout_idx !== h_idx || dout_last !== h_last) begin
          n_fail++;
          $display("FAIL bp_hold: v=%b re=%0d idx=%0d last=%b, expected held re=%0d idx=%0d last=%b",
                   dout_valid, dout_re, dout_idx, dout_last, h_re, h_idx, h_last);
        end
      end
      dout_ready = pat[c % 16];
      hold_v = (dout_valid === 1'b1) && !dout_ready;
      h_re = dout_re; h_im = dout_im; h_idx = dout_idx; h_last = dout_last;
      if (dout_valid === 1'b1 && dout_ready) begin
        n_checks++;
        if (dout_re !== DATA_W'(exp_n) || dout_im !== im_of(exp_n) ||
            dout_idx !== IDX_W'(exp_n % 64) || dout_last !== ((exp_n % 64) == 63)) begin
          n_fail++;
          $display("FAIL bp_word[%0d]: re=%0d idx=%0d last=%b, expected re=%0d idx=%0d",
                   exp_n, dout_re, dout_idx, dout_last, exp_n, exp_n % 64);
        end
        exp_n++;
      end
      tick();
    end
    drive(1'b0, 0);
    dout_ready = 1'b0;
    n_checks++;
    if (exp_n != 128 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL bp_end: words=%0d ovf=%b, expected 128 0", exp_n, overflow);
    end
  endtask

  task automatic test_collision();
    int exp_n, fed, ev;
    exp_n = 0; fed = 1;
    do_reset();
    for (int i = 0; i < 128; i++) begin drive(1'b1, i); tick(); end
    drive(1'b0, 0);
    dout_ready = 1'b1;
    for (int c = 0; c < 200 && !(dout_valid === 1'b1 && dout_idx == 6'd63); c++) tick();
    n_checks++;
    if (dout_valid !== 1'b1 || dout_last !== 1'b1 || dout_re !== DATA_W'(63)) begin
      n_fail++;
      $display("FAIL coll_setup: v=%b last=%b re=%0d, expected 1 1 63", dout_valid, dout_last, dout_re);
    end
    drive(1'b1, 500);
    tick();
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL coll_ovf: overflow=%b, expected 0", overflow);
    end
    for (int c = 0; c < 400 && exp_n < 128; c++) begin
      if (fed < 64) begin drive(1'b1, 500 + fed); fed++; end else drive(1'b0, 0);
      if (dout_valid === 1'b1) begin
        ev = (exp_n < 64) ? 64 + exp_n : 500 + exp_n - 64;
        n_checks++;
        if (dout_re !== DATA_W'(ev) || dout_im !== im_of(ev) ||
            dout_idx !== IDX_W'(exp_n % 64) || dout_last !== ((exp_n % 64) == 63)) begin
          n_fail++;
          $display("FAIL coll_word[%0d]: re=%0d idx=%0d last=%b, expected re=%0d idx=%0d",
                   exp_n, dout_re, dout_idx, dout_last, ev, exp_n % 64);
        end
        exp_n++;
      end
      tick();
    end
    drive(1'b0, 0);
    n_checks++;
    if (exp_n != 128 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL coll_end: words=%0d ovf=%b, expected 128 0", exp_n, overflow);
    end
  endtask

  task automatic test_reset_mid();
    int exp_n;
    exp_n = 0;
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin drive(1'b1, 900 + i); tick(); end
    drive(1'b1, 777);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (dout_valid !== 1'b0 || dout_last !== 1'b0 || dout_idx !== '0 ||
        dout_re !== '0 || dout_im !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in: v=%b last=%b idx=%0d re=%h im=%h ovf=%b, expected all 0",
               dout_valid, dout_last, dout_idx, dout_re, dout_im, overflow);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin drive(1'b1, i); tick(); end
    drive(1'b0, 0);
    for (int c = 0; c < 20 && !(dout_valid === 1'b1 && dout_idx == 6'd10); c++) tick();
    n_checks++;
    if (dout_valid !== 1'b1 || dout_idx !== 6'd10 || dout_re !== DATA_W'(10)) begin
      n_fail++;
      $display("FAIL rst_word10: v=%b idx=%0d re=%0d, expected 1 10 10", dout_valid, dout_idx, dout_re);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (dout_valid !== 1'b0 || dout_last !== 1'b0 || dout_idx !== '0 ||
        dout_re !== '0 || dout_im !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_out: v=%b last=%b idx=%0d re=%h im=%h ovf=%b, expected all 0",
               dout_valid, dout_last, dout_idx, dout_re, dout_im, overflow);
    end
    tick();
    reset = 1'b1;
    for (int c = 0; c < 200 && exp_n < 64; c++) begin
      if (c < 64) drive(1'b1, 2000 + c); else drive(1'b0, 0);
      if (dout_valid === 1'b1) begin
        n_checks++;
        if (dout_re !== DATA_W'(2000 + exp_n) || dout_im !== im_of(2000 + exp_n) ||
            dout_idx !== IDX_W'(exp_n) || dout_last !== (exp_n == 63)) begin
          n_fail++;
          $display("FAIL rst_word[%0d]: re=%0d idx=%0d last=%b, expected re=%0d idx=%0d",
                   exp_n, dout_re, dout_idx, dout_last, 2000 + exp_n, exp_n);
        end
        exp_n++;
      end
      tick();
    end
    drive(1'b0, 0);
    repeat (3) tick();
    n_checks++;
    if (exp_n != 64 || dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_end: words=%0d v=%b, expected 64 0", exp_n, dout_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_two_frames();
    test_overflow();
    test_backpressure();
    test_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

endmodule
